// File: rtl/mac_divider_pkg.sv
// Shared constants and types for the multiply-add / divide datapath pair.
package mac_divider_pkg;

  // Operand width (multiplier inputs, divisor, remainder).
  localparam int MAC_WIDTH     = 8;
  // Product / dividend width (nominally 2*MAC_WIDTH).
  localparam int MAC_OUT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [MAC_OUT_WIDTH-1:0] dividend_t;
  typedef logic [MAC_WIDTH-1:0]     operand_t;

endpackage

// File: rtl/mac_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mac_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   partial,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   next_partial,
  output logic             q_bit
);

  // The partial remainder stays below the divisor, so the shifted value is
  // below 2*divisor and one extra bit is enough to hold the trial's sign.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  assign shifted      = {partial, in_bit};
  assign trial        = shifted - {2'b00, divisor};
  assign q_bit        = ~trial[WIDTH+1];
  assign next_partial = q_bit ? (WIDTH+1)'(trial) : (WIDTH+1)'(shifted);

endmodule

// File: rtl/mac_divider.sv
// Sequential restoring divider that recovers A and C from DATA = A*B + C,
// producing one quotient bit per clock behind a start/busy/done handshake.
module mac_divider
  import mac_divider_pkg::*;
#(
  parameter int WIDTH     = MAC_WIDTH,
  parameter int OUT_WIDTH = MAC_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [OUT_WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0]     DIVISOR,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [OUT_WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0]     REMAINDER
);

  localparam int CNT_W = $clog2(OUT_WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(OUT_WIDTH - 1);

  state_t               state;
  // Dividend bits shift out of the top while quotient bits shift in at the
  // bottom, so after OUT_WIDTH steps this register holds the quotient.
  logic [OUT_WIDTH-1:0] work;
  logic [WIDTH-1:0]     divisor_q;
  logic [WIDTH:0]       partial;
  logic [CNT_W-1:0]     count;
  // Zero divisor: result is published one cycle after acceptance.
  logic                 zero_pending;

  logic [WIDTH:0]       next_partial;
  logic                 q_bit;
  logic                 accept;

  mac_div_step #(.WIDTH(WIDTH)) u_step (
    .partial     (partial),
    .in_bit      (work[OUT_WIDTH-1]),
    .divisor     (divisor_q),
    .next_partial(next_partial),
    .q_bit       (q_bit)
  );

  // A new request is taken in IDLE, or in the result cycle of DONE.
  assign accept = start && ((state == IDLE) || (state == DONE && !zero_pending));

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: working registers are cleared as well, so an aborted operation
      // leaves nothing behind for the next one.
      state        <= IDLE;
      work         <= '0;
      divisor_q    <= '0;
      partial      <= '0;
      count        <= '0;
      zero_pending <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      div_by_zero  <= 1'b0;
      QUOTIENT     <= '0;
      REMAINDER    <= '0;
    end else if (accept) begin
      // NOTE: non-blocking assignments, so every term on the right is the
      // pre-edge value regardless of statement order.
      work      <= DIVIDEND;
      divisor_q <= DIVISOR;
      partial   <= '0;
      count     <= CNT_INIT;
      done      <= 1'b0;
      if (DIVISOR == '0) begin
        state        <= DONE;
        zero_pending <= 1'b1;
        busy         <= 1'b0;
      end else begin
        state        <= CALC;
        zero_pending <= 1'b0;
        busy         <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
        end

        CALC: begin
          partial <= next_partial;
          work    <= {work[OUT_WIDTH-2:0], q_bit};
          count   <= count - 1'b1;
          if (count == '0) begin
            QUOTIENT    <= {work[OUT_WIDTH-2:0], q_bit};
            REMAINDER   <= next_partial[WIDTH-1:0];
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end
        end

        DONE: begin
          if (zero_pending) begin
            QUOTIENT     <= '1;
            REMAINDER    <= work[WIDTH-1:0];
            div_by_zero  <= 1'b1;
            done         <= 1'b1;
            zero_pending <= 1'b0;
          end else begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          done         <= 1'b0;
          zero_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_divider.sv
// Randomised scoreboard bench for mac_divider.
module tb_mac_divider;
  import mac_divider_pkg::*;

  localparam int W  = MAC_WIDTH;
  localparam int OW = MAC_OUT_WIDTH;

  typedef struct packed {
    logic [OW-1:0] q;
    logic [W-1:0]  r;
    logic          dz;
  } result_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [OW-1:0] DIVIDEND = '0;
  logic [W-1:0]  DIVISOR = '0;
  logic          busy, done, div_by_zero;
  logic [OW-1:0] QUOTIENT;
  logic [W-1:0]  REMAINDER;

  result_t sb[$];
  int      n_checks = 0;
  int      n_pass   = 0;
  int      cyc      = 0;

  mac_divider #(.WIDTH(W), .OUT_WIDTH(OW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .DIVIDEND   (DIVIDEND),
    .DIVISOR    (DIVISOR),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .QUOTIENT   (QUOTIENT),
    .REMAINDER  (REMAINDER)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain integer division, with the zero-divisor convention.
  function automatic result_t model(input logic [OW-1:0] dvd, input logic [W-1:0] dvs);
    result_t res;
    if (dvs == 0) begin
      res.q  = '1;
      res.r  = dvd[W-1:0];
      res.dz = 1'b1;
    end else begin
      res.q  = dvd / OW'(dvs);
      res.r  = W'(dvd % OW'(dvs));
      res.dz = 1'b0;
    end
    return res;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_done: done=1 with no pending result (cycle %0d)", cyc);
      end else begin
        result_t e;
        e = sb.pop_front();
        check("quotient",    32'(QUOTIENT),    32'(e.q));
        check("remainder",   32'(REMAINDER),   32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
      end
    end
  end

  // Present operands with start high at a negedge; the next posedge is t0.
  task automatic issue(input logic [OW-1:0] dvd, input logic [W-1:0] dvs, input result_t exp);
    @(negedge clk);
    DIVIDEND = dvd;
    DIVISOR  = dvs;
    start    = 1'b1;
    sb.push_back(exp);
  endtask

  task automatic wait_done(input int budget, output int at_cyc);
    bit seen = 0;
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen   = 1;
        at_cyc = cyc;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL done_timeout: no done within %0d cycles (cycle %0d)", budget, cyc);
    end
  endtask

  // One isolated operation with latency and busy checks.
  task automatic run_op(input logic [OW-1:0] dvd, input logic [W-1:0] dvs, input result_t exp);
    int c0, cd;
    issue(dvd, dvs, exp);
    @(negedge clk);
    c0    = cyc;
    start = 1'b0;
    check("busy_after_start", 32'(busy), (dvs != 0) ? 32'd1 : 32'd0);
    wait_done(40, cd);
    check("latency", 32'(cd - c0), (dvs != 0) ? 32'(OW) : 32'd1);
  endtask

  initial begin
    int d1, d2, c0;
    logic [OW-1:0] a, dvd;
    logic [W-1:0]  b, c;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_dz",   32'(div_by_zero), 0);
    check("rst_q",    32'(QUOTIENT), 0);
    check("rst_r",    32'(REMAINDER), 0);
    reset = 1'b0;

    // Directed cases, expectations written from the arithmetic directly.
    run_op(16'd200,   8'd7,   '{q: 16'd28,     r: 8'd4,   dz: 1'b0});
    run_op(16'd65279, 8'd255, '{q: 16'd255,    r: 8'd254, dz: 1'b0});
    run_op(16'h1234,  8'd1,   '{q: 16'h1234,   r: 8'd0,   dz: 1'b0});
    run_op(16'd100,   8'd0,   '{q: 16'hFFFF,   r: 8'd100, dz: 1'b1});
    run_op(16'h0100,  8'd1,   model(16'h0100, 8'd1));
    run_op(16'hFFFF,  8'd3,   model(16'hFFFF, 8'd3));

    // start held high; operands change during CALC; back-to-back accept.
    issue(16'd200, 8'd7, '{q: 16'd28, r: 8'd4, dz: 1'b0});
    @(negedge clk);
    c0       = cyc;
    DIVIDEND = 16'd65279;
    DIVISOR  = 8'd255;
    sb.push_back(model(16'd65279, 8'd255));
    wait_done(40, d1);
    check("b2b_latency", 32'(d1 - c0), 32'(OW));
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 1);
    repeat (5) @(negedge clk);
    check("hold_q_midcalc", 32'(QUOTIENT), 28);
    check("hold_r_midcalc", 32'(REMAINDER), 4);
    wait_done(40, d2);
    check("done_spacing", 32'(d2 - d1), 32'(OW + 1));

    // Asynchronous reset in the middle of an operation.
    issue(16'd200, 8'd7, model(16'd200, 8'd7));
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_q",    32'(QUOTIENT), 0);
    check("arst_r",    32'(REMAINDER), 0);
    check("arst_dz",   32'(div_by_zero), 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    run_op(16'd200, 8'd7, '{q: 16'd28, r: 8'd4, dz: 1'b0});

    // Random round trips of the multiply-add stage.
    for (int i = 0; i < 1000; i++) begin
      a   = OW'($urandom_range(0, (1 << W) - 1));
      b   = W'($urandom_range(1, (1 << W) - 1));
      c   = W'($urandom_range(0, int'(b) - 1));
      dvd = a * OW'(b) + OW'(c);
      run_op(dvd, b, '{q: a, r: c, dz: 1'b0});
    end

    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_divider.md
Name: mac_divider

Overview:
- Sequential restoring divider that undoes the registered multiply-add stage: given DATA = A*B + C and the divisor B, it recovers the quotient A and the remainder C.
- Sits downstream of the multiply-add register in the datapath, or on a verification/readback path.
- Computes one quotient bit per clock and uses a start/busy/done handshake.
- WIDTH and OUT_WIDTH come from the shared parameter include, so both stages stay width-consistent.

Parameters:
- WIDTH, 8, operand width (divisor and remainder).
- OUT_WIDTH, 16, dividend and quotient width; must be >= WIDTH (nominally 2*WIDTH).

Ports:
- clk  input  1  system clock (200 MHz domain)
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when not busy
- DIVIDEND  input  OUT_WIDTH  dividend (A*B+C word)
- DIVISOR  input  WIDTH  divisor (B)
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when results are valid
- div_by_zero  output  1  flag for the last completed operation
- QUOTIENT  output  OUT_WIDTH  quotient (A)
- REMAINDER  output  WIDTH  remainder (C)

Behaviour:
- Reset: the asynchronous assert of reset, at any time including mid-operation, forces
  - state to IDLE;
  - busy, done, div_by_zero to 0;
  - QUOTIENT and REMAINDER to 0;
  - all internal registers to 0.
  Release takes effect on the next clk edge; the operation in flight is discarded.
- FSM states: IDLE, CALC, DONE. Only the declared states are used; any illegal encoding returns to IDLE.
- IDLE/DONE with start=1 at edge t0:
  - DIVIDEND and DIVISOR are latched internally;
  - partial remainder (WIDTH+1 bits) is cleared, iteration counter set to OUT_WIDTH-1;
  - if DIVISOR==0, go to DONE instead, see the zero-divisor rule below;
  - otherwise go to CALC with busy=1.
- CALC, each edge:
  - shift {partial, dividend} left one bit;
  - trial = partial - divisor;
  - if trial is non-negative, partial <= trial and the quotient LSB is 1, else the LSB is 0;
  - decrement the counter.
  - The last iteration happens at edge t0+OUT_WIDTH. At that edge: QUOTIENT and REMAINDER are registered, div_by_zero=0, done=1, busy=0, state goes to DONE.
- Latency: start is sampled at t0 and done is high during the cycle after edge t0+OUT_WIDTH (exactly OUT_WIDTH edges). Throughput is one operation per OUT_WIDTH+1 cycles when back-to-back.
- DONE:
  - done is high for exactly that one cycle;
  - start=1 in the same cycle is accepted exactly as in IDLE (back-to-back);
  - otherwise go to IDLE.
- Zero divisor: done pulses after edge t0+1 with
  - QUOTIENT = all ones;
  - REMAINDER = DIVIDEND[WIDTH-1:0];
  - div_by_zero = 1;
  - busy stays 0.
- start while busy: ignored. Latched operands do not change, and input changes during CALC have no effect.
- Holding: QUOTIENT, REMAINDER and div_by_zero hold their values until the next done or reset. They are never changed mid-calculation.
- Arithmetic: unsigned. The remainder is always < DIVISOR. If QUOTIENT fits in WIDTH bits, then QUOTIENT*DIVISOR + REMAINDER == DIVIDEND exactly, with no truncation anywhere.
- start is held high continuously: a new operation is accepted at each DONE cycle.

Decomposition:
- Shared package / params include:
  - WIDTH and OUT_WIDTH (the same constants the multiply-add stage uses);
  - the typedef of the state enum {IDLE, CALC, DONE};
  - typedefs for the dividend-width and operand-width words.
- One natural sub-module: mac_div_step. It is combinational and takes partial remainder, incoming bit and divisor, and produces the next partial remainder and the quotient bit. It is instantiated once and iterated by the FSM.
- The counter width is $clog2(OUT_WIDTH).

Test Plan:
- DIVIDEND=200, DIVISOR=7, start pulse at t0 -> busy for 16 cycles, done one cycle after edge t0+16, QUOTIENT=28, REMAINDER=4, div_by_zero=0.
- DIVIDEND=65279 (255*255+254), DIVISOR=255 -> QUOTIENT=255, REMAINDER=254; round trip matches the multiply-add stage output.
- DIVIDEND=0x1234, DIVISOR=1 -> QUOTIENT=0x1234, REMAINDER=0. Then DIVIDEND=100, DIVISOR=0 -> done after t0+1, QUOTIENT=0xFFFF, REMAINDER=100, div_by_zero=1.
- start held high with new operands applied during CALC -> mid-operation operands ignored, first result unaffected. Second operation starts in the DONE cycle, with done pulses exactly 17 cycles apart.
- Reset asserted asynchronously at iteration 8 -> immediately busy=0, done=0, QUOTIENT=0, REMAINDER=0. After release, a fresh 200/7 gives 28 r 4.
- Random A, B (B!=0) and C<B with DIVIDEND=A*B+C: 1000 vectors -> QUOTIENT==A and REMAINDER==C for every vector.
